scoreboard_ctrl: RTL
====================

// Module: scoreboard_ctrl
// PURPOSE
//   Hazard scheduler for the decode stage: tracks outstanding register writes of instructions issued
//   from decode to execute, and drives the decode stage stall.
//   Decode is held until every enabled source register, and its own destination, is free of pending
//   writes (RAW/WAW). Also provides a drain handshake so fence/CSR sequencing can wait for an empty pipe.
// PARAMETERS
//   NUM_REGS  32  architectural registers tracked; index 0 (x0) never tracked
//   CNT_W     2   width of per-register pending-write counter (max 2**CNT_W-1 in flight per reg)
// PORTS
//   i_clk           in   1         clock, all state on posedge
//   i_rst           in   1         reset, asynchronous, active-high
//   i_rs1_en        in   1         decode instruction reads rs1
//   i_rs1_addr      in   5         rs1 index
//   i_rs2_en        in   1         decode instruction reads rs2
//   i_rs2_addr      in   5         rs2 index
//   i_rd_we         in   1         decode instruction writes rd
//   i_rd_addr       in   5         rd index
//   i_issue         in   1         decode->execute handshake (valid && ready) this cycle
//   i_issue_rd_we   in   1         issued instruction writes a register
//   i_issue_rd      in   5         issued instruction rd index
//   i_wb_valid      in   1         writeback commits a register write this cycle
//   i_wb_rd         in   5         writeback rd index
//   i_kill_valid    in   1         an issued writer was squashed by flush (returns its slot)
//   i_kill_rd       in   5         squashed writer rd index
//   i_drain_req     in   1         request: wait until no writes pending
//   o_stall         out  1         hazard on decode instruction; wired to decode i_stall
//   o_busy          out  NUM_REGS  bit r = counter[r] != 0 (bit 0 always 0)
//   o_drain_ack     out  1         drain complete; high while in DONE
//   o_err           out  1         sticky: counter overflow or underflow attempted
// BEHAVIOUR
//   - Reset (async): all counters 0, FSM IDLE, o_err 0. Hence o_busy 0, o_drain_ack 0, o_stall 0.
//   - Counter update per register r != 0, once per cycle: next = cnt + inc - dec_wb - dec_kill.
//     inc = i_issue && i_issue_rd_we && i_issue_rd == r.
//     dec_wb = i_wb_valid && i_wb_rd == r. dec_kill = i_kill_valid && i_kill_rd == r.
//     Any mix of events may hit the same r in one cycle; net result applies (e.g. issue+wb -> unchanged).
//     The result is computed in CNT_W+2 bit signed arithmetic.
//     If the result < 0: clamp to 0 and set o_err. If the result > 2**CNT_W-1: clamp to max and set o_err.
//     Events with index 0 are ignored.
//   - o_stall is combinational from registered counters, with no same-cycle writeback bypass:
//     (i_rs1_en && cnt[rs1]!=0) || (i_rs2_en && cnt[rs2]!=0) || (i_rd_we && cnt[rd]!=0).
//     Operands at index 0 never stall.
//     A wb in cycle N clears the hazard; o_stall falls in cycle N+1 (regfile write visible in N+1).
//   - Drain FSM:
//     IDLE  -> DRAIN on i_drain_req.
//     DRAIN: o_stall forced 1, blocking new issue. -> DONE when all counters 0 (may be the same
//       cycle the last wb lands, evaluated on next-state counters).
//     DONE: o_drain_ack=1, o_stall forced 1. -> IDLE when i_drain_req deasserts.
//     If counters are already 0 when the request arrives: IDLE->DRAIN->DONE, ack at +2 cycles.
//   - An issue asserted together with o_stall=1 is a protocol violation; it is still counted.
//   - Reset mid-operation (any FSM state, counters nonzero) returns everything to reset values immediately.
// TESTING
//   1. Issue rd=5 at cycle 0. Decode reads rs1=5. -> o_stall=1, o_busy[5]=1. Wb rd=5 at cycle 3 -> o_stall=0 at cycle 4.
//   2. Issue rd=7 and wb rd=7 together while cnt[7]=1 -> cnt[7] stays 1, o_busy[7]=1, o_err=0.
//   3. Three issues to rd=3 (CNT_W=2, reaching max 3). Decode has rd_we, rd=3 -> o_stall=1; a fourth issue -> o_err=1, cnt stays 3.
//   4. Issue rd=9, then kill rd=9 -> o_busy[9]=0 next cycle. Extra wb rd=9 -> clamp 0, o_err=1.
//   5. Pending rd=4, rd=6. Assert i_drain_req -> o_stall=1 throughout.
//      Both wb land -> o_drain_ack=1. Drop req -> IDLE, ack 0.
//   6. Issue rd=0 with rs1=0/rs2=0 in decode -> o_busy[0]=0 and o_stall=0. Async reset pulse mid-DRAIN -> all outputs 0.

Source files
------------

// File: rtl/scoreboard_ctrl.sv
// Register scoreboard for the decode stage.
// Keeps a small saturating counter of in-flight writes for each architectural
// register. Decode is stalled on RAW/WAW hazards against those counters. A
// drain handshake lets fence/CSR sequencing wait until no writes are pending.
module scoreboard_ctrl #(
  parameter int NUM_REGS = 32,
  parameter int CNT_W    = 2
) (
  input  logic                i_clk,
  input  logic                i_rst,
  input  logic                i_rs1_en,
  input  logic [4:0]          i_rs1_addr,
  input  logic                i_rs2_en,
  input  logic [4:0]          i_rs2_addr,
  input  logic                i_rd_we,
  input  logic [4:0]          i_rd_addr,
  input  logic                i_issue,
  input  logic                i_issue_rd_we,
  input  logic [4:0]          i_issue_rd,
  input  logic                i_wb_valid,
  input  logic [4:0]          i_wb_rd,
  input  logic                i_kill_valid,
  input  logic [4:0]          i_kill_rd,
  input  logic                i_drain_req,
  output logic                o_stall,
  output logic [NUM_REGS-1:0] o_busy,
  output logic                o_drain_ack,
  output logic                o_err
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRAIN = 2'd1,
    DONE  = 2'd2
  } state_t;

  // Two extra bits give room for the sign and for cnt+1 without wrapping.
  localparam int SUM_W = CNT_W + 2;
  localparam logic signed [SUM_W-1:0] CNT_MAX_S = SUM_W'((1 << CNT_W) - 1);

  logic [CNT_W-1:0]        cnt      [NUM_REGS];
  logic [CNT_W-1:0]        cnt_next [NUM_REGS];
  logic signed [SUM_W-1:0] sum;
  logic                    inc;
  logic                    dec_wb;
  logic                    dec_kill;
  logic                    err_set;
  logic                    all_zero_next;
  logic                    hazard;
  state_t                  state;
  state_t                  state_next;

  // Net per-register update for this cycle, with saturation and error flagging.
  always_comb begin
    // NOTE: every combinational output gets a default before any branch, so no path can infer a latch.
    sum           = '0;
    inc           = 1'b0;
    dec_wb        = 1'b0;
    dec_kill      = 1'b0;
    err_set       = 1'b0;
    all_zero_next = 1'b1;
    cnt_next[0]   = '0;
    for (int r = 1; r < NUM_REGS; r++) begin
      inc      = i_issue && i_issue_rd_we && (i_issue_rd == 5'(r));
      dec_wb   = i_wb_valid && (i_wb_rd == 5'(r));
      dec_kill = i_kill_valid && (i_kill_rd == 5'(r));
      sum      = SUM_W'(cnt[r]) + SUM_W'(inc) - SUM_W'(dec_wb) - SUM_W'(dec_kill);
      if (sum[SUM_W-1]) begin
        cnt_next[r] = '0;
        err_set     = 1'b1;
      end else if (sum > CNT_MAX_S) begin
        cnt_next[r] = '1;
        err_set     = 1'b1;
      end else begin
        cnt_next[r] = sum[CNT_W-1:0];
      end
      if (cnt_next[r] != '0) begin
        all_zero_next = 1'b0;
      end
    end
  end

  // Counter array and sticky error flag.
  always_ff @(posedge i_clk or posedge i_rst) begin
    // NOTE: the counter array is reset explicitly; a flush or reset must leave no phantom pending writes.
    if (i_rst) begin
      for (int r = 0; r < NUM_REGS; r++) begin
        cnt[r] <= '0;
      end
      o_err <= 1'b0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
      for (int r = 0; r < NUM_REGS; r++) begin
        cnt[r] <= cnt_next[r];
      end
      if (err_set) begin
        o_err <= 1'b1;
      end
    end
  end

  // Busy vector straight from the registered counters; x0 is never tracked.
  always_comb begin
    o_busy = '0;
    for (int r = 1; r < NUM_REGS; r++) begin
      o_busy[r] = (cnt[r] != '0);
    end
  end

  // Hazard check against registered counters only (no same-cycle writeback bypass).
  always_comb begin
    hazard = (i_rs1_en && (i_rs1_addr != 5'd0) && (cnt[i_rs1_addr] != '0)) ||
             (i_rs2_en && (i_rs2_addr != 5'd0) && (cnt[i_rs2_addr] != '0)) ||
             (i_rd_we  && (i_rd_addr  != 5'd0) && (cnt[i_rd_addr]  != '0));
  end

  // Drain FSM state register.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Drain FSM next state and outputs; decode is held in any non-idle state.
  always_comb begin
    state_next  = state;
    o_drain_ack = 1'b0;
    o_stall     = hazard;
    case (state)
      IDLE: begin
        if (i_drain_req) begin
          state_next = DRAIN;
        end
      end
      DRAIN: begin
        o_stall = 1'b1;
        // Looks at next-state counters so the last writeback completes the drain in its own cycle.
        if (all_zero_next) begin
          state_next = DONE;
        end
      end
      DONE: begin
        o_stall     = 1'b1;
        o_drain_ack = 1'b1;
        if (!i_drain_req) begin
          state_next = IDLE;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

endmodule
